// File: rtl/peak_bin_tracker.sv
// Per-frame peak-bin tracker with a hit/miss debounce FSM and a frame watchdog.
// Outputs update on the cycle after a valid last sample; the watchdog forces LOST when frames stall.
module peak_bin_tracker #(
   parameter int unsigned MAG_THRESHOLD  = 5000,
   parameter int unsigned ON_FRAMES      = 3,
   parameter int unsigned OFF_FRAMES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        bin_valid_in,
   input  logic [3:0]  bin_idx_in,
   input  logic [24:0] bin_mag_in,
   input  logic        bin_last_in,
   output logic [3:0]  bin,
   output logic [24:0] mag,
   output logic        recognised,
   output logic        frame_done,
   output logic        timeout
);

   localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      ON_CNT  = 4'(ON_FRAMES);
   localparam logic [3:0]      OFF_CNT = 4'(OFF_FRAMES);
   localparam logic [24:0]     THR     = 25'(MAG_THRESHOLD);

   typedef enum logic [1:0] {LOST, ACQUIRE, LOCKED, RELEASE} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [WD_W-1:0] wd_cnt;
   logic            have_first;
   logic [3:0]      run_bin;
   logic [24:0]     run_mag;

   logic            take;
   logic [3:0]      peak_bin;
   logic [24:0]     peak_mag;
   logic            frame_end;
   logic            hit;
   logic            wd_expire;

   // Strict > keeps the earlier sample on ties; an empty frame always loads.
   always_comb begin
      take      = !have_first || (bin_mag_in > run_mag);
      peak_bin  = take ? bin_idx_in : run_bin;
      peak_mag  = take ? bin_mag_in : run_mag;
      frame_end = bin_valid_in && bin_last_in;
      hit       = peak_mag >= THR;
      wd_expire = (wd_cnt == WD_LAST);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         bin        <= '0;
         mag        <= '0;
         frame_done <= 1'b0;
         have_first <= 1'b0;
         run_bin    <= '0;
         run_mag    <= '0;
         wd_cnt     <= '0;
      end else begin
         frame_done <= 1'b0;
         if (bin_valid_in) begin
            if (bin_last_in) begin
               bin        <= peak_bin;
               mag        <= peak_mag;
               frame_done <= 1'b1;
               have_first <= 1'b0;
            end else begin
               run_bin    <= peak_bin;
               run_mag    <= peak_mag;
               have_first <= 1'b1;
            end
         end
         // A frame end in the expiry cycle wins; otherwise expiry drops the partial frame.
         if (frame_end) begin
            wd_cnt <= '0;
         end else if (wd_expire) begin
            wd_cnt     <= '0;
            have_first <= 1'b0;
         end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state      <= LOST;
         cnt        <= '0;
         recognised <= 1'b0;
         timeout    <= 1'b0;
      end else if (frame_end) begin
         timeout <= 1'b0;
         case (state)
            LOST: begin
               if (hit) begin
                  if (ON_CNT == 4'd1) begin
                     state      <= LOCKED;
                     cnt        <= '0;
                     recognised <= 1'b1;
                  end else begin
                     state <= ACQUIRE;
                     cnt   <= 4'd1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            ACQUIRE: begin
               if (hit) begin
                  if (cnt + 4'd1 == ON_CNT) begin
                     state      <= LOCKED;
                     cnt        <= '0;
                     recognised <= 1'b1;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end else begin
                  state <= LOST;
                  cnt   <= '0;
               end
            end
            LOCKED: begin
               if (!hit) begin
                  if (OFF_CNT == 4'd1) begin
                     state      <= LOST;
                     cnt        <= '0;
                     recognised <= 1'b0;
                  end else begin
                     state <= RELEASE;
                     cnt   <= 4'd1;
                  end
               end
            end
            RELEASE: begin
               if (!hit) begin
                  if (cnt + 4'd1 == OFF_CNT) begin
                     state      <= LOST;
                     cnt        <= '0;
                     recognised <= 1'b0;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end else begin
                  state <= LOCKED;
                  cnt   <= '0;
               end
            end
            default: begin
               state      <= LOST;
               cnt        <= '0;
               recognised <= 1'b0;
            end
         endcase
      end else if (wd_expire) begin
         state      <= LOST;
         cnt        <= '0;
         recognised <= 1'b0;
         timeout    <= 1'b1;
      end
   end

endmodule

// File: doc/peak_bin_tracker.md
PEAK_BIN_TRACKER -- requirements
Module: peak_bin_tracker

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-002 Parameters SHALL be:
- MAG_THRESHOLD, default 5000, minimum peak magnitude counted as a hit.
- ON_FRAMES, default 3, consecutive hit frames needed to assert recognised.
- OFF_FRAMES, default 4, consecutive miss frames needed to deassert recognised.
- TIMEOUT_CYCLES, default 2_000_000, maximum number of cycles between frame ends.
REQ-003 Ports SHALL be:
- clk_in, input, 1, clock at 98.304 MHz.
- rst_in, input, 1, synchronous active-low reset.
- bin_valid_in, input, 1, current bin sample is valid.
- bin_idx_in, input, 4, bin index 0-15.
- bin_mag_in, input, 25, unsigned bin magnitude.
- bin_last_in, input, 1, final sample of frame; qualified by bin_valid_in.
- bin, output, 4, peak bin of the last completed frame.
- mag, output, 25, peak magnitude of the last completed frame.
- recognised, output, 1, debounced target-present flag.
- frame_done, output, 1, single-cycle pulse when bin/mag update.
- timeout, output, 1, sticky watchdog flag.

Function
REQ-004 A frame SHALL consist of all valid samples from the first valid after reset or after a last, up to and including the next valid sample with bin_last_in=1.
REQ-005 Within a frame, the block SHALL track the running maximum using a strict greater-than comparison, so that ties keep the earlier sample.
REQ-006 The first valid sample of a frame SHALL always load the running maximum, regardless of its magnitude (including 0).
REQ-007 Cycles with bin_valid_in=0 SHALL leave all frame state unchanged; gaps of any length are legal.
REQ-008 On a valid last sample, the final peak SHALL include that sample.
REQ-009 On the cycle after a valid last sample:
- bin and mag SHALL update to the final peak.
- frame_done SHALL pulse high for one cycle.
- Accumulation SHALL restart, so that a valid sample in that same cycle is frame N+1's first sample.
REQ-010 A frame SHALL be a hit when its final peak magnitude is >= MAG_THRESHOLD, and a miss otherwise.
REQ-011 Recognition SHALL be a four-state machine, with transitions evaluated only at frame end:
- LOST (recognised=0): a hit goes to ACQUIRE with count=1; if ON_FRAMES=1, it goes directly to LOCKED.
- ACQUIRE (recognised=0): a hit increments count, and the count reaching ON_FRAMES goes to LOCKED; a miss goes to LOST.
- LOCKED (recognised=1): a miss goes to RELEASE with count=1; if OFF_FRAMES=1, it goes directly to LOST.
- RELEASE (recognised=1): a miss increments count, and the count reaching OFF_FRAMES goes to LOST; a hit goes to LOCKED.
REQ-012 recognised SHALL change in the same cycle that frame_done pulses, never between frame ends.
REQ-013 The frame counter SHALL be 4 bits wide, and ON_FRAMES and OFF_FRAMES SHALL be limited to 1-15.
REQ-014 The watchdog counter SHALL count cycles since the last frame end (or since reset) and SHALL clear on every frame end.
REQ-015 When the watchdog count reaches TIMEOUT_CYCLES:
- The FSM SHALL go to LOST and recognised SHALL be 0 on the next cycle.
- The partial frame SHALL be discarded.
- timeout SHALL be set.
- The watchdog SHALL restart.
REQ-016 timeout SHALL clear at the next frame end; that frame SHALL be evaluated normally from LOST.
REQ-017 If a timeout and a valid last sample occur in the same cycle, the frame end SHALL take priority and the watchdog SHALL clear.
REQ-018 bin_idx_in SHALL be captured as-is; out-of-order or repeated indices SHALL be legal and SHALL be treated purely as data.
REQ-019 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-020 While rst_in=0 at a clock edge, the block SHALL set bin=0, mag=0, recognised=0, frame_done=0, timeout=0, FSM=LOST, frame counter=0, and watchdog=0, and SHALL discard any partial frame.
REQ-021 A reset applied mid-frame SHALL cause the first valid sample after reset release to start a new frame.
REQ-022 Inputs sampled in a cycle with rst_in=0 SHALL be ignored.

Verification
REQ-023 Peak/tie scenario:
- Stimulus: 16 samples with magnitude 100 for all bins, except bin 5 = 9000 and bin 9 = 9000.
- Required response: bin=5, mag=9000, and frame_done high for exactly one cycle, one cycle after last.
REQ-024 Debounce-on scenario (ON_FRAMES=3):
- Stimulus: frame peaks of 6000, 6000, 4000, 6000, 6000, 6000.
- Required response: recognised stays 0 through frame 5 and rises with frame 6's frame_done.
REQ-025 Debounce-off scenario (OFF_FRAMES=4, starting LOCKED):
- Stimulus: frames of miss, miss, miss, hit, then four misses.
- Required response: recognised stays 1 until the eighth frame's frame_done.
REQ-026 Gaps scenario:
- Stimulus: random bin_valid_in gaps of 0-20 cycles, and a last sample followed immediately by a valid first sample.
- Required response: per-frame peaks match a reference model, with no sample lost or double-counted.
REQ-027 Timeout scenario (TIMEOUT_CYCLES=50, starting LOCKED):
- Stimulus: stall with no last sample for 50 cycles.
- Required response: recognised=0 and timeout=1; the next hit frame goes to ACQUIRE and clears timeout.
REQ-028 Reset scenario:
- Stimulus: assert rst_in=0 for one cycle mid-frame while LOCKED.
- Required response: all outputs reach their reset values; the following frame's peak excludes the pre-reset samples.
